count_sequencer: RTL

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_seq_pkg.sv | 6 +
 rtl/count_core.sv | 22 ++
 rtl/count_sequencer.sv | 71 +++++++
 3 files changed

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state type and default sizes for the count sequencer.
package count_seq_pkg;
   localparam int DEF_WIDTH = 4;
   localparam int DEF_LAP_W = 8;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
endpackage

// File: rtl/count_core.sv
// count_core: counter with synchronous clear, enable and terminal-count compare.
module count_core
   import count_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] tc_i,
   output logic [WIDTH-1:0] q_o,
   output logic             at_tc_o
);
   logic [WIDTH-1:0] q_q, q_d;
   always_comb q_d = clr_i ? '0 : en_i ? q_q + 1'b1 : q_q;
   always_ff @(posedge clk)
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   assign q_o     = q_q;
   assign at_tc_o = q_q == tc_i;
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: IDLE/RUN/PAUSE control around count_core with
// one-shot or auto-reload terminal count and a saturating lap counter.
module count_sequencer
   import count_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LAP_W = DEF_LAP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_tc,
   input  logic             cfg_reload,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic [LAP_W-1:0] laps
);
   state_t           state_q;
   logic [WIDTH-1:0] tc_q;
   logic             reload_q;
   logic             done_q;
   logic [LAP_W-1:0] laps_q;
   logic             launch, advance, wrap, at_tc;
   assign launch  = state_q == IDLE && start;
   assign advance = state_q == RUN && !stop && !pause;
   assign wrap    = advance && at_tc;
   count_core #(.WIDTH(WIDTH)) u_core (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (launch || wrap),
      .en_i    (advance),
      .tc_i    (tc_q),
      .q_o     (q),
      .at_tc_o (at_tc)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tc_q     <= '1;
         reload_q <= 1'b0;
         done_q   <= 1'b0;
         laps_q   <= '0;
      end else begin
         done_q <= wrap;
         if (state_q == IDLE && cfg_valid) begin
            tc_q     <= cfg_tc;
            reload_q <= cfg_reload;
         end
         if (launch) laps_q <= '0;
         else if (wrap && laps_q != '1) laps_q <= laps_q + 1'b1;
         case (state_q)
            IDLE:    if (start) state_q <= RUN;
            RUN:     if (stop) state_q <= IDLE;
                     else if (pause) state_q <= PAUSE;
                     else if (wrap && !reload_q) state_q <= IDLE;
            PAUSE:   if (stop) state_q <= IDLE;
                     else if (!pause) state_q <= RUN;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign cfg_ready = state_q == IDLE;
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign laps      = laps_q;
endmodule
